// File: rtl/jesd207_burst_sched.sv
// JESD207 burst scheduler: arbitrates TX/RX requests and sequences the ENABLE/FIFO enables.
// Optional burst counters are built only when JESD207_BURST_CNT_EN is defined.
module jesd207_burst_sched #(
  parameter int LW        = 8,
  parameter int SETUP_CYC = 2,
  parameter int GUARD_CYC = 4
) (
  input  logic          fclk,
  input  logic          rstn,
  input  logic          tx_req,
  input  logic [LW-1:0] tx_len,
  input  logic          rx_req,
  input  logic [LW-1:0] rx_len,
  input  logic          rempty,
  input  logic          wfull,
  output logic          tx_nrx,
  output logic          jesd_en,
  output logic          rd_en,
  output logic          wr_en,
  output logic          tx_gnt,
  output logic          rx_gnt,
  output logic          busy,
  output logic          done,
  output logic          short,
  output logic [15:0]   tx_burst_cnt,
  output logic [15:0]   rx_burst_cnt
);

  typedef enum logic [2:0] {IDLE, SETUP, START, TRANS, STOP, GUARD} state_e;

  // SETUP spans the grant cycle plus SETUP_CYC cycles of stable tx_nrx.
  localparam logic [3:0]    SETUP_LAST = 4'(SETUP_CYC);
  localparam logic [3:0]    GUARD_LAST = 4'(GUARD_CYC - 1);
  localparam logic [LW-1:0] LEN_ONE    = LW'(1);

  state_e        state_q, state_d;
  logic [3:0]    cyc_q, cyc_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic [LW-1:0] len_q, len_d;
  logic          dir_q, dir_d;
  logic          last_dir_q, last_dir_d;
  logic          tx_nrx_q, tx_nrx_d;
  logic          short_q, short_d;

  logic          tx_elig, rx_elig, pick_tx, len_hit, flag;
  logic [LW-1:0] cnt_inc;

  assign tx_elig = tx_req & (|tx_len);
  assign rx_elig = rx_req & (|rx_len);
  // last_dir = 0 means RX went last, so TX wins a tie.
  assign pick_tx = tx_elig & (~rx_elig | ~last_dir_q);
  assign cnt_inc = cnt_q + LEN_ONE;
  assign len_hit = (cnt_inc == len_q);
  assign flag    = dir_q ? rempty : wfull;

  always_ff @(posedge fclk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      cyc_q      <= '0;
      cnt_q      <= '0;
      len_q      <= '0;
      dir_q      <= 1'b1;
      last_dir_q <= 1'b0;
      tx_nrx_q   <= 1'b1;
      short_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      dir_q      <= dir_d;
      last_dir_q <= last_dir_d;
      tx_nrx_q   <= tx_nrx_d;
      short_q    <= short_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    dir_d      = dir_q;
    last_dir_d = last_dir_q;
    tx_nrx_d   = tx_nrx_q;
    short_d    = short_q;
    case (state_q)
      IDLE: begin
        if (tx_elig || rx_elig) begin
          dir_d      = pick_tx;
          last_dir_d = pick_tx;
          tx_nrx_d   = pick_tx;
          len_d      = pick_tx ? tx_len : rx_len;
          cyc_d      = '0;
          state_d    = SETUP;
        end
      end
      SETUP: begin
        if (cyc_q == SETUP_LAST) state_d = START;
        else                     cyc_d   = cyc_q + 4'd1;
      end
      START: begin
        cnt_d   = '0;
        state_d = TRANS;
      end
      TRANS: begin
        cnt_d = cnt_inc;
        // A FIFO flag on the final sample is a normal end, not a short one.
        if (len_hit || flag) begin
          short_d = flag & ~len_hit;
          state_d = STOP;
        end
      end
      STOP: begin
        cyc_d   = '0;
        state_d = GUARD;
      end
      GUARD: begin
        if (cyc_q == GUARD_LAST) state_d = IDLE;
        else                     cyc_d   = cyc_q + 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_q != IDLE);
    jesd_en = (state_q == START) || (state_q == STOP);
    rd_en   = (state_q == TRANS) && dir_q;
    wr_en   = (state_q == TRANS) && !dir_q;
    tx_gnt  = (state_q == SETUP) && (cyc_q == 4'd0) && dir_q;
    rx_gnt  = (state_q == SETUP) && (cyc_q == 4'd0) && !dir_q;
    done    = (state_q == STOP);
    short   = (state_q == STOP) && short_q;
    tx_nrx  = tx_nrx_q;
  end

`ifdef JESD207_BURST_CNT_EN
  logic [15:0] tx_bcnt_q, rx_bcnt_q;

  always_ff @(posedge fclk or negedge rstn) begin
    if (!rstn) begin
      tx_bcnt_q <= '0;
      rx_bcnt_q <= '0;
    end else if (state_q == STOP) begin
      if (dir_q) tx_bcnt_q <= tx_bcnt_q + 16'd1;
      else       rx_bcnt_q <= rx_bcnt_q + 16'd1;
    end
  end

  assign tx_burst_cnt = tx_bcnt_q;
  assign rx_burst_cnt = rx_bcnt_q;
`else
  assign tx_burst_cnt = 16'd0;
  assign rx_burst_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_jesd207_burst_sched.sv
// Bench for jesd207_burst_sched: per-cycle comparison against a timeline model of each burst.
module tb_jesd207_burst_sched;
  localparam int LW = 8;
  localparam int S  = 2;
  localparam int G  = 4;
  localparam int NO_STOP = 1000;

  logic          fclk = 1'b0;
  logic          rstn;
  logic          tx_req, rx_req, rempty, wfull;
  logic [LW-1:0] tx_len, rx_len;
  logic          tx_nrx, jesd_en, rd_en, wr_en, tx_gnt, rx_gnt, busy, done, short;
  logic [15:0]   tx_burst_cnt, rx_burst_cnt;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic        last_dir_m;
  logic [15:0] exp_txb, exp_rxb;

  jesd207_burst_sched #(.LW(LW), .SETUP_CYC(S), .GUARD_CYC(G)) dut (
    .fclk(fclk), .rstn(rstn),
    .tx_req(tx_req), .tx_len(tx_len), .rx_req(rx_req), .rx_len(rx_len),
    .rempty(rempty), .wfull(wfull),
    .tx_nrx(tx_nrx), .jesd_en(jesd_en), .rd_en(rd_en), .wr_en(wr_en),
    .tx_gnt(tx_gnt), .rx_gnt(rx_gnt), .busy(busy), .done(done), .short(short),
    .tx_burst_cnt(tx_burst_cnt), .rx_burst_cnt(rx_burst_cnt)
  );

  always #5 fclk = ~fclk;

  function automatic logic [15:0] cnt_exp(input logic [15:0] v);
`ifdef JESD207_BURST_CNT_EN
    return v;
`else
    return 16'd0;
`endif
  endfunction

  // Present one request pair in IDLE and follow the resulting burst cycle by cycle.
  // m = enable cycle during which the direction's FIFO flag is raised (NO_STOP = never).
  task automatic drive_burst(input logic treq, input logic [LW-1:0] tlen, input logic rreq,
                             input logic [LW-1:0] rlen, input int m, input string tag);
    logic te, re, d, s;
    int L, E, last_k, lat;
    logic [8:0] ev, ov;
    te = treq && (tlen != 0);
    re = rreq && (rlen != 0);
    tx_req = treq; tx_len = tlen; rx_req = rreq; rx_len = rlen;
    rempty = 1'b0; wfull = 1'b0;
    if (!te && !re) begin
      for (int i = 0; i < 3; i++) begin
        @(negedge fclk);
        n_checks++;
        if ({tx_gnt, rx_gnt, busy} !== 3'b000) begin
          n_fail++;
          $display("FAIL %s no_grant: gnt/gnt/busy=%b required 000", tag, {tx_gnt, rx_gnt, busy});
        end
      end
      tx_req = 1'b0; rx_req = 1'b0;
      return;
    end
    d = te && (!re || !last_dir_m);
    L = d ? int'(tlen) : int'(rlen);
    s = (m < L);
    E = s ? m : L;
    lat = -1;
    for (int i = 0; i < 4; i++) begin
      @(negedge fclk);
      if (tx_gnt || rx_gnt) begin
        lat = i;
        break;
      end
    end
    n_checks++;
    if (lat != 0) begin
      n_fail++;
      $display("FAIL %s grant_latency: got %0d required 0", tag, lat);
      if (lat < 0) begin
        tx_req = 1'b0; rx_req = 1'b0;
        return;
      end
    end
    last_dir_m = d;
    last_k = 3 + S + E + G;
    for (int k = 0; k <= last_k; k++) begin
      if (k > 0) @(negedge fclk);
      ev = {(k == 0) && d, (k == 0) && !d, k <= 2 + S + E + G,
            (k == 1 + S) || (k == 2 + S + E),
            d && (k >= 2 + S) && (k <= 1 + S + E),
            !d && (k >= 2 + S) && (k <= 1 + S + E),
            k == 2 + S + E, (k == 2 + S + E) && s, d};
      ov = {tx_gnt, rx_gnt, busy, jesd_en, rd_en, wr_en, done, short, tx_nrx};
      n_checks++;
      if (ov !== ev) begin
        n_fail++;
        $display("FAIL %s cycle%0d {txg,rxg,busy,en,rd,wr,done,short,txnrx}: got %b required %b",
                 tag, k, ov, ev);
      end
      if (k < last_k) begin
        // Inputs after the grant must be ignored until IDLE.
        tx_req = 1'($urandom); tx_len = LW'($urandom);
        rx_req = 1'($urandom); rx_len = LW'($urandom);
        if (d) begin rempty = (k == 1 + S + m); wfull  = 1'($urandom); end
        else   begin wfull  = (k == 1 + S + m); rempty = 1'($urandom); end
      end else begin
        tx_req = 1'b0; rx_req = 1'b0; tx_len = '0; rx_len = '0;
        rempty = 1'b0; wfull = 1'b0;
      end
    end
    if (d) exp_txb = exp_txb + 16'd1;
    else   exp_rxb = exp_rxb + 16'd1;
    n_checks++;
    if (tx_burst_cnt !== cnt_exp(exp_txb) || rx_burst_cnt !== cnt_exp(exp_rxb)) begin
      n_fail++;
      $display("FAIL %s burst_cnt: got tx=%0d rx=%0d required tx=%0d rx=%0d", tag,
               tx_burst_cnt, rx_burst_cnt, cnt_exp(exp_txb), cnt_exp(exp_rxb));
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    tx_req = 1'b1; tx_len = 8'd5; rx_req = 1'b1; rx_len = 8'd5;
    rempty = 1'b0; wfull = 1'b0;
    last_dir_m = 1'b0; exp_txb = '0; exp_rxb = '0;
    repeat (3) @(negedge fclk);
    n_checks++;
    if ({jesd_en, rd_en, wr_en, tx_gnt, rx_gnt, busy, done, short, tx_nrx} !== 9'b0_0000_0001) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b required 000000001",
               {jesd_en, rd_en, wr_en, tx_gnt, rx_gnt, busy, done, short, tx_nrx});
    end
    n_checks++;
    if (tx_burst_cnt !== 16'd0 || rx_burst_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_cnt: got tx=%0d rx=%0d required 0 0", tx_burst_cnt, rx_burst_cnt);
    end
    tx_req = 1'b0; rx_req = 1'b0; tx_len = '0; rx_len = '0;
    rstn = 1'b1;
  endtask

  task automatic test_contention(input string tag);
    for (int i = 0; i < 3; i++) drive_burst(1'b1, 8'd3, 1'b1, 8'd3, NO_STOP, tag);
  endtask

  task automatic test_single_tx();
    drive_burst(1'b1, 8'd5, 1'b0, 8'd0, NO_STOP, "single_tx");
  endtask

  task automatic test_early_stop();
    drive_burst(1'b0, 8'd0, 1'b1, 8'd10, 4, "rx_early_stop");
    drive_burst(1'b1, 8'd7, 1'b0, 8'd0, 2, "tx_early_stop");
    drive_burst(1'b1, 8'd3, 1'b0, 8'd0, 3, "same_cycle_stop");
    drive_burst(1'b0, 8'd1, 1'b1, 8'd1, 1, "len1_same_cycle");
  endtask

  task automatic test_zero_len();
    drive_burst(1'b1, 8'd0, 1'b1, 8'd2, NO_STOP, "zero_len_a");
    drive_burst(1'b1, 8'd0, 1'b1, 8'd2, NO_STOP, "zero_len_b");
    drive_burst(1'b1, 8'd0, 1'b0, 8'd0, NO_STOP, "zero_len_only");
  endtask

  task automatic test_random();
    for (int i = 0; i < 16; i++) begin
      drive_burst(1'($urandom), LW'($urandom_range(0, 9)), 1'($urandom), LW'($urandom_range(0, 9)),
                  ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 10)) : NO_STOP, "random");
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    tx_req = 1'b1; tx_len = 8'd8; rx_req = 1'b0; rx_len = '0;
    lat = -1;
    for (int i = 0; i < 4; i++) begin
      @(negedge fclk);
      if (tx_gnt) begin
        lat = i;
        break;
      end
    end
    n_checks++;
    if (lat < 0) begin
      n_fail++;
      $display("FAIL reset_mid_grant: got no tx_gnt required tx_gnt");
    end
    repeat (2 + S + 1) @(negedge fclk);
    n_checks++;
    if (rd_en !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_in_trans: got rd_en=%b required 1", rd_en);
    end
    #2 rstn = 1'b0;
    #1;
    n_checks++;
    if ({rd_en, jesd_en, busy, done, tx_nrx} !== 5'b00001 ||
        tx_burst_cnt !== 16'd0 || rx_burst_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_mid_async: got rd/en/busy/done/txnrx=%b cnt=%0d/%0d required 00001 0/0",
               {rd_en, jesd_en, busy, done, tx_nrx}, tx_burst_cnt, rx_burst_cnt);
    end
    tx_req = 1'b0; tx_len = '0;
    @(posedge fclk);
    @(negedge fclk);
    rstn = 1'b1;
    last_dir_m = 1'b0; exp_txb = '0; exp_rxb = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge fclk);
      n_checks++;
      if ({busy, jesd_en, done} !== 3'b000) begin
        n_fail++;
        $display("FAIL reset_mid_no_stop: got busy/en/done=%b required 000", {busy, jesd_en, done});
      end
    end
  endtask

  initial begin
    test_reset();
    test_contention("contention");
    test_single_tx();
    test_early_stop();
    test_zero_len();
    test_random();
    test_reset_mid();
    test_contention("contention_after_reset");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule
